mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter that shares the single-port 256×16 program/data RAM between the CPU memory interface (`mem_cmd`/`mem_addr`) and a debug/loader port. It sits between `cpu` and the RAM macro, sequences every access through a fixed three-cycle grant/access/response FSM and stalls the CPU via `cpu_wait`. The CPU state machine holds its current state and command while `cpu_wait` is high.

## Interface
- `AW`, 9, CPU address width (matches `mem_addr`)
- `DW`, 16, data width
- `RAW`, 8, RAM address width; RAM depth is 2^RAW
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `cpu_cmd`  in  2  2'b01 MREAD, 2'b10 MWRITE, 2'b00/2'b11 no request
- `cpu_addr`  in  AW  CPU word address
- `cpu_wdata`  in  DW  CPU write data
- `cpu_rdata`  out  DW  CPU read data
- `cpu_wait`  out  1  CPU stall; high while a CPU command is pending and not completing
- `bus_err`  out  1  one-cycle pulse: CPU access with `cpu_addr[AW-1:RAW]` ≠ 0
- `dbg_req`  in  1  debug request, level, held until `dbg_ack`
- `dbg_we`  in  1  1 = write, 0 = read
- `dbg_addr`  in  RAW  debug address
- `dbg_wdata`  in  DW  debug write data
- `dbg_ack`  out  1  one-cycle completion pulse
- `dbg_rdata`  out  DW  debug read data, registered, held until next debug read
- `ram_addr`  out  RAW  registered RAM address
- `ram_we`  out  1  registered RAM write enable
- `ram_din`  out  DW  registered RAM write data
- `ram_dout`  in  DW  RAM read data, valid one cycle after the address edge

## Operation
- FSM states: IDLE, ACCESS, RESP. `owner` register records the granted port (CPU/DBG).
- IDLE:
  - No valid request: stay in IDLE, outputs unchanged, `ram_we` = 0.
  - Otherwise select a winner (see Configuration), load `ram_addr`/`ram_din`/`ram_we` and `owner`, go to ACCESS.
  - `ram_we` = 1 only for MWRITE or `dbg_we` = 1.
- ACCESS: the RAM samples the address/write. `ram_we` clears at the end of ACCESS. Go to RESP.
- RESP:
  - If `owner` = CPU: `cpu_rdata` = `ram_dout` combinationally and is also captured into the hold register; `cpu_wait` = 0.
  - If `owner` = DBG: `dbg_ack` = 1 and `dbg_rdata` <= `ram_dout` (reads only).
  - Go to IDLE.
- `cpu_wait` = (`cpu_cmd` ∈ {01,10}) AND NOT (state = RESP AND `owner` = CPU). Outside RESP, `cpu_rdata` shows the hold register.
- Out-of-range CPU address (upper bits ≠ 0):
  - Follows the same three-state sequence and `ram_we` stays 0.
  - In RESP, `cpu_rdata` = 16'h0000 and `bus_err` = 1.
  - No RAM write occurs.
- A requester that still presents a command after completion is treated as a new request in the following IDLE.
- A request arriving while the other port owns the RAM waits. For CPU, `cpu_wait` stays high. It competes in the next IDLE.
- Write data and address are sampled only at the IDLE→ACCESS edge; later changes have no effect on the in-flight access.

## Timing
- Request visible in cycle N (IDLE) → ACCESS in N+1 → RESP in N+2 → IDLE in N+3.
- CPU: `cpu_wait` is high in N and N+1, low in N+2. Read data is valid in N+2.
- Debug: `dbg_ack` is high in N+2 only. `dbg_rdata` is valid from N+3 onward.
- Peak throughput: one access per 3 cycles.
- Reset, asynchronous and taking effect immediately, including mid-access:
  - Clears state → IDLE and `owner` → CPU.
  - Clears `ram_addr`, `ram_we`, `ram_din`, the `cpu_rdata` hold register, `dbg_rdata`, `dbg_ack` and `bus_err` to 0. `last_gnt` → DBG.
  - An aborted access is not completed; requesters reissue it.
  - `cpu_wait` remains combinational during reset, high if `cpu_cmd` is valid.

## Configuration
- `ARB_RR_EN` defined: round-robin arbitration.
  - On a simultaneous request in IDLE, grant the port opposite `last_gnt`, then update `last_gnt`.
  - The CPU wins the first tie after reset.
- `ARB_RR_EN` undefined: fixed priority, CPU always wins ties. The debug port is granted only in an IDLE cycle with no valid CPU command. `last_gnt` is not implemented.

## Test plan
- CPU MREAD with RAM[0x05] = 16'hABCD, `cpu_cmd` = 01, `cpu_addr` = 9'h005 at cycle N → `cpu_wait` high in N and N+1, low in N+2 with `cpu_rdata` = 16'hABCD; `ram_we` never 1.
- CPU MWRITE of 16'h1234 to 9'h0FF → `ram_we` = 1 for exactly cycle N+1 with `ram_addr` = 8'hFF; a subsequent MREAD of 9'h0FF returns 16'h1234.
- CPU MREAD of 9'h140 → no RAM write; in N+2 `cpu_rdata` = 16'h0000 and `bus_err` = 1 for one cycle.
- CPU and debug requesting every cycle (debug read 8'h10):
  - With `ARB_RR_EN`, grants alternate CPU, DBG, CPU, DBG; `dbg_ack` every 6 cycles.
  - Without it, `dbg_ack` never pulses until `cpu_cmd` = 00.
- Debug write 16'h00FF to 8'h20, then debug read of 8'h20 → `dbg_ack` pulses in N+2 of each access; `dbg_rdata` = 16'h00FF from the cycle after the second ack.
- Assert reset in the ACCESS cycle of a CPU MWRITE → `ram_we` drops to 0 immediately, the state returns to IDLE and the RAM word is unchanged. After release, the held command completes three cycles later.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between the CPU memory interface and a
// debug/loader port. Every access runs a fixed IDLE -> ACCESS -> RESP sequence;
// the CPU is stalled through cpu_wait_o until its RESP cycle.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   cpu_cmd_i/addr_i/wdata_i      CPU command (01 read, 10 write), address, write data
//   cpu_rdata_o, cpu_wait_o       CPU read data, CPU stall
//   bus_err_o                     one-cycle pulse for an out-of-range CPU access
//   dbg_req_i/we_i/addr_i/wdata_i debug request (level), direction, address, write data
//   dbg_ack_o, dbg_rdata_o        debug completion pulse, registered debug read data
//   ram_addr_o/we_o/din_o         registered RAM controls
//   ram_dout_i                    RAM read data, valid one cycle after the address edge
//
// Build option: define ARB_RR_EN for round-robin arbitration; otherwise the CPU
// has fixed priority over the debug port.
module mem_arbiter #(
  parameter int unsigned AW  = 9,
  parameter int unsigned DW  = 16,
  parameter int unsigned RAW = 8
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [1:0]     cpu_cmd_i,
  input  logic [AW-1:0]  cpu_addr_i,
  input  logic [DW-1:0]  cpu_wdata_i,
  output logic [DW-1:0]  cpu_rdata_o,
  output logic           cpu_wait_o,
  output logic           bus_err_o,
  input  logic           dbg_req_i,
  input  logic           dbg_we_i,
  input  logic [RAW-1:0] dbg_addr_i,
  input  logic [DW-1:0]  dbg_wdata_i,
  output logic           dbg_ack_o,
  output logic [DW-1:0]  dbg_rdata_o,
  output logic [RAW-1:0] ram_addr_o,
  output logic           ram_we_o,
  output logic [DW-1:0]  ram_din_o,
  input  logic [DW-1:0]  ram_dout_i
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  localparam logic OwnCpu = 1'b0;
  localparam logic OwnDbg = 1'b1;

  state_e         state_q, state_d;
  logic           owner_q, owner_d;
  logic           bad_q, bad_d;        // in-flight CPU access is out of range
  logic           acc_we_q, acc_we_d;  // in-flight access is a write
  logic [RAW-1:0] ram_addr_q, ram_addr_d;
  logic           ram_we_q, ram_we_d;
  logic [DW-1:0]  ram_din_q, ram_din_d;
  logic [DW-1:0]  cpu_hold_q, cpu_hold_d;
  logic [DW-1:0]  dbg_rdata_q, dbg_rdata_d;

  logic          cpu_valid, cpu_oor, cpu_resp, grant_dbg;
  logic [DW-1:0] cpu_resp_data;

  assign cpu_valid     = (cpu_cmd_i == 2'b01) || (cpu_cmd_i == 2'b10);
  assign cpu_oor       = |cpu_addr_i[AW-1:RAW];
  assign cpu_resp      = (state_q == StResp) && (owner_q == OwnCpu);
  assign cpu_resp_data = bad_q ? '0 : ram_dout_i;

`ifdef ARB_RR_EN
  logic last_gnt_q, last_gnt_d;

  // On a tie the port opposite the last grant wins.
  assign grant_dbg  = dbg_req_i && (!cpu_valid || (last_gnt_q == OwnCpu));
  assign last_gnt_d = ((state_q == StIdle) && (cpu_valid || dbg_req_i)) ?
                      grant_dbg : last_gnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_gnt_q <= OwnDbg;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end
`else
  assign grant_dbg = dbg_req_i && !cpu_valid;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    bad_d       = bad_q;
    acc_we_d    = acc_we_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_din_d   = ram_din_q;
    cpu_hold_d  = cpu_hold_q;
    dbg_rdata_d = dbg_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_valid || dbg_req_i) begin
          state_d = StAccess;
          if (grant_dbg) begin
            owner_d    = OwnDbg;
            bad_d      = 1'b0;
            acc_we_d   = dbg_we_i;
            ram_addr_d = dbg_addr_i;
            ram_din_d  = dbg_wdata_i;
            ram_we_d   = dbg_we_i;
          end else begin
            owner_d    = OwnCpu;
            bad_d      = cpu_oor;
            acc_we_d   = (cpu_cmd_i == 2'b10);
            ram_addr_d = cpu_addr_i[RAW-1:0];
            ram_din_d  = cpu_wdata_i;
            // An out-of-range write must never reach the RAM.
            ram_we_d   = (cpu_cmd_i == 2'b10) && !cpu_oor;
          end
        end
      end
      StAccess: begin
        state_d = StResp;
      end
      StResp: begin
        state_d = StIdle;
        if (owner_q == OwnCpu) begin
          cpu_hold_d = cpu_resp_data;
        end else if (!acc_we_q) begin
          dbg_rdata_d = ram_dout_i;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      owner_q     <= OwnCpu;
      bad_q       <= 1'b0;
      acc_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_din_q   <= '0;
      cpu_hold_q  <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      bad_q       <= bad_d;
      acc_we_q    <= acc_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_din_q   <= ram_din_d;
      cpu_hold_q  <= cpu_hold_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // cpu_wait_o stays combinational so it is valid even while reset is held.
  assign cpu_wait_o  = cpu_valid && !cpu_resp;
  assign cpu_rdata_o = cpu_resp ? cpu_resp_data : cpu_hold_q;
  assign bus_err_o   = cpu_resp && bad_q;
  assign dbg_ack_o   = (state_q == StResp) && (owner_q == OwnDbg);
  assign dbg_rdata_o = dbg_rdata_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_we_o    = ram_we_q;
  assign ram_din_o   = ram_din_q;

endmodule
